// File: rtl/search_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | search_sequencer_if : command, counter and hash-pipeline signal bundle    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface search_sequencer_if;
  logic        start;
  logic        pause;
  logic        step_req;
  logic        clear;
  logic [29:0] count;
  logic        cnt_done;
  logic        match;
  logic        cnt_reset;
  logic        cnt_enable;
  logic        cnt_step;
  logic        cand_valid;
  logic [2:0]  state;
  logic        found;
  logic [29:0] found_value;
  logic [8:0]  in_flight;

  modport master (
    output start, pause, step_req, clear, count, cnt_done, match,
    input  cnt_reset, cnt_enable, cnt_step, cand_valid, state, found,
           found_value, in_flight
  );

  modport slave (
    input  start, pause, step_req, clear, count, cnt_done, match,
    output cnt_reset, cnt_enable, cnt_step, cand_valid, state, found,
           found_value, in_flight
  );
endinterface

`default_nettype wire

// File: rtl/search_sequencer.sv
// +--------------------------------------------------------------------------+
// | search_sequencer : candidate search control FSM with match attribution    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module search_sequencer #(
  parameter int unsigned LATENCY = 64
) (
  input  wire logic          CLK,
  input  wire logic          reset,
  search_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_PAUSE     = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_FOUND     = 3'd4,
    ST_EXHAUSTED = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_step;
  logic                w_step_next;
  logic                r_cnt_reset;
  logic [29:0]         r_found_value;
  logic [8:0]          r_in_flight;
  logic [LATENCY-1:0]  r_vld;
  logic [29:0]         r_val [LATENCY];

  logic                w_flush;
  logic                w_enable;
  logic                w_cand_valid;
  logic                w_tail_vld;
  logic                w_qual_match;

  assign w_flush      = reset | bus.clear;
  assign w_enable     = (r_state == ST_RUN);
  assign w_cand_valid = (w_enable | r_step) & ~bus.cnt_done;
  assign w_tail_vld   = r_vld[LATENCY-1];
  // Only the first qualified hit is kept; FOUND ignores later ones.
  assign w_qual_match = bus.match & w_tail_vld & (r_state != ST_FOUND);

  always_comb begin
    w_state_next = r_state;
    w_step_next  = 1'b0;
    if (bus.clear) begin
      w_state_next = ST_IDLE;
    end else if (w_qual_match) begin
      w_state_next = ST_FOUND;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.pause) begin
            w_state_next = ST_IDLE;
          end else if (bus.start) begin
            w_state_next = ST_RUN;
          end else if (bus.step_req) begin
            w_state_next = ST_PAUSE;
            w_step_next  = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.cnt_done) begin
            w_state_next = ST_DRAIN;
          end else if (bus.pause) begin
            w_state_next = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (bus.cnt_done) begin
            w_state_next = ST_DRAIN;
          end else if (bus.pause) begin
            w_state_next = ST_PAUSE;
          end else if (bus.start) begin
            w_state_next = ST_RUN;
          end else if (bus.step_req) begin
            w_step_next = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_in_flight == 9'd0) begin
            w_state_next = ST_EXHAUSTED;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK) begin
    r_cnt_reset <= w_flush;
    if (w_flush) begin
      r_step        <= 1'b0;
      r_found_value <= 30'd0;
      r_in_flight   <= 9'd0;
    end else begin
      r_step      <= w_step_next;
      r_in_flight <= r_in_flight + {8'd0, w_cand_valid} - {8'd0, w_tail_vld};
      if (w_qual_match) begin
        r_found_value <= r_val[LATENCY-1];
      end
    end
  end

  // Values need no flush: a cleared valid bit makes the entry inert.
  always_ff @(posedge CLK) begin
    if (w_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_cand_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
    r_val[0] <= bus.count;
    for (int i = 1; i < LATENCY; i++) begin
      r_val[i] <= r_val[i-1];
    end
  end

  assign bus.cnt_reset   = reset | r_cnt_reset;
  assign bus.cnt_enable  = w_enable;
  assign bus.cnt_step    = r_step;
  assign bus.cand_valid  = w_cand_valid;
  assign bus.state       = r_state;
  assign bus.found       = (r_state == ST_FOUND);
  assign bus.found_value = r_found_value;
  assign bus.in_flight   = r_in_flight;

endmodule

`default_nettype wire

// File: tb/tb_search_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_search_sequencer : directed bench with candidate-issue scoreboard      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_search_sequencer;
  localparam int          LAT  = 4;
  localparam logic [29:0] MAXC = 30'h1FFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] load_base = 30'd0;
  logic [29:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  logic        hit_seen;

  search_sequencer_if bus ();

  search_sequencer #(.LATENCY(LAT)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 30-bit counter: holds at MAXC, done flag one cycle later.
  always @(posedge clk) begin
    if (bus.cnt_reset) begin
      bus.count    <= load_base;
      bus.cnt_done <= 1'b0;
    end else begin
      bus.cnt_done <= (bus.count == MAXC);
      if ((bus.cnt_enable || bus.cnt_step) && bus.count != MAXC)
        bus.count <= bus.count + 30'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_range(input logic [29:0] lo, input logic [29:0] hi);
    for (logic [30:0] v = {1'b0, lo}; v <= {1'b0, hi}; v++) exp_q.push_back(v[29:0]);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("clear_cnt_reset", 32'(bus.cnt_reset), 32'd1);
    check("clear_state", 32'(bus.state), 32'd0);
    check("clear_in_flight", 32'(bus.in_flight), 32'd0);
    check("clear_found_value", 32'(bus.found_value), 32'd0);
    @(negedge clk);
    check("clear_cnt_reset_drop", 32'(bus.cnt_reset), 32'd0);
  endtask

  // Scoreboard: every issued candidate must be the next expected value.
  always @(negedge clk) begin
    if (bus.cand_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL extra_cand observed=%0h expected=none", bus.count);
      end else begin
        check("cand", 32'(bus.count), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.step_req = 1'b0;
    bus.clear = 1'b0; bus.match = 1'b0;

    // Reset values
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("cnt_reset_in_reset", 32'(bus.cnt_reset), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_cnt_reset_after", 32'(bus.cnt_reset), 32'd1);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_cnt_enable", 32'(bus.cnt_enable), 32'd0);
    check("rst_cnt_step", 32'(bus.cnt_step), 32'd0);
    check("rst_cand_valid", 32'(bus.cand_valid), 32'd0);
    check("rst_found", 32'(bus.found), 32'd0);
    check("rst_found_value", 32'(bus.found_value), 32'd0);
    check("rst_in_flight", 32'(bus.in_flight), 32'd0);
    @(negedge clk);
    check("rst_cnt_reset_drop", 32'(bus.cnt_reset), 32'd0);

    // Run to hit on candidate 0x123
    push_range(30'd0, 30'h127);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("run_state", 32'(bus.state), 32'd1);
    check("run_enable", 32'(bus.cnt_enable), 32'd1);
    check("run_first_count", 32'(bus.count), 32'd0);
    hit_seen = 1'b0;
    for (int i = 0; i < 1000 && !hit_seen; i++) begin
      if (bus.cand_valid === 1'b1 && bus.count == 30'h123) hit_seen = 1'b1;
      else @(negedge clk);
    end
    check("hit_candidate_seen", 32'(hit_seen), 32'd1);
    repeat (LAT) @(negedge clk);
    bus.match = 1'b1;
    check("found_before_match", 32'(bus.found), 32'd0);
    @(negedge clk);
    bus.match = 1'b0;
    check("hit_found", 32'(bus.found), 32'd1);
    check("hit_found_value", 32'(bus.found_value), 32'h123);
    check("hit_state", 32'(bus.state), 32'd4);
    check("hit_enable_low", 32'(bus.cnt_enable), 32'd0);
    bus.match = 1'b1;
    @(negedge clk);
    bus.match = 1'b0;
    check("later_match_ignored", 32'(bus.found_value), 32'h123);
    @(negedge clk);
    check("hit_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    do_clear();

    // Pause after 10 candidates, then three single steps
    push_range(30'd0, 30'd12);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.pause = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
    check("pause_state", 32'(bus.state), 32'd2);
    check("pause_enable", 32'(bus.cnt_enable), 32'd0);
    check("pause_count", 32'(bus.count), 32'd10);
    for (int s = 0; s < 3; s++) begin
      bus.step_req = 1'b1;
      @(negedge clk);
      bus.step_req = 1'b0;
      check("step_pulse", 32'(bus.cnt_step), 32'd1);
      @(negedge clk);
      check("step_pulse_end", 32'(bus.cnt_step), 32'd0);
    end
    check("step_count", 32'(bus.count), 32'd13);
    check("step_state", 32'(bus.state), 32'd2);
    bus.start = 1'b1; bus.pause = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.pause = 1'b0;
    check("pause_beats_start", 32'(bus.state), 32'd2);
    check("step_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    do_clear();

    // Stray match, then clear mid-run
    push_range(30'd0, 30'd5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.match = 1'b1;
    @(negedge clk);
    bus.match = 1'b0;
    check("stray_state", 32'(bus.state), 32'd1);
    check("stray_found", 32'(bus.found), 32'd0);
    repeat (3) @(negedge clk);
    check("midrun_in_flight", 32'(bus.in_flight), 32'd4);
    do_clear();
    check("clear_enable_low", 32'(bus.cnt_enable), 32'd0);
    bus.match = 1'b1;
    @(negedge clk);
    bus.match = 1'b0;
    check("post_clear_match_state", 32'(bus.state), 32'd0);
    check("post_clear_match_found", 32'(bus.found), 32'd0);
    check("clear_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-run
    push_range(30'd0, 30'd5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("prereset_in_flight", 32'(bus.in_flight), 32'd4);
    reset = 1'b1;
    #1;
    check("midrun_cnt_reset_during", 32'(bus.cnt_reset), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrun_cnt_reset_after", 32'(bus.cnt_reset), 32'd1);
    check("midrun_reset_state", 32'(bus.state), 32'd0);
    check("midrun_reset_in_flight", 32'(bus.in_flight), 32'd0);
    @(negedge clk);
    check("midrun_cnt_reset_drop", 32'(bus.cnt_reset), 32'd0);
    bus.match = 1'b1;
    @(negedge clk);
    bus.match = 1'b0;
    check("post_reset_match_state", 32'(bus.state), 32'd0);
    check("post_reset_match_found", 32'(bus.found), 32'd0);
    check("reset_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Exhaustion from 0x1FFFFFFC
    load_base = 30'h1FFFFFFC;
    do_clear();
    push_range(30'h1FFFFFFC, MAXC);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("exh_run_state", 32'(bus.state), 32'd1);
    repeat (4) @(negedge clk);
    check("exh_last_run_state", 32'(bus.state), 32'd1);
    check("exh_in_flight", 32'(bus.in_flight), 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("exh_drain_state", 32'(bus.state), 32'd3);
    end
    @(negedge clk);
    check("exh_state", 32'(bus.state), 32'd5);
    check("exh_in_flight_zero", 32'(bus.in_flight), 32'd0);
    check("exh_enable_low", 32'(bus.cnt_enable), 32'd0);
    check("exh_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Match on 0x1FFFFFFE while draining
    do_clear();
    push_range(30'h1FFFFFFC, MAXC);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("drain_before_match", 32'(bus.state), 32'd3);
    bus.match = 1'b1;
    @(negedge clk);
    bus.match = 1'b0;
    check("drain_hit_state", 32'(bus.state), 32'd4);
    check("drain_hit_value", 32'(bus.found_value), 32'h1FFFFFFE);
    repeat (4) @(negedge clk);
    check("drain_hit_stays_found", 32'(bus.state), 32'd4);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
